// File: rtl/load_align_pkg.sv
// Shared types, sizes and decode helpers for the load alignment unit.
package load_align_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_funct3_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        W0   = 3'd2,
        RD1  = 3'd3,
        W1   = 3'd4,
        DONE = 3'd5
    } state_e;

    function automatic logic is_legal_funct3(input logic [2:0] f3);
        case (f3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // A load needs a second word when its last byte lands past the first word.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == LH || f3 == LHU) && off == 2'd3) || (f3 == LW && off != 2'd0);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Realigns a byte/halfword/word from a two-word window and sign/zero-extends it.
module load_extract
    import load_align_pkg::*;
(
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] r;

    always_comb begin
        r    = DATA_W'({hi, lo} >> {off, 3'b000});
        data = '0;
        case (funct3)
            LB:      data = {{24{r[7]}}, r[7:0]};
            LBU:     data = {24'd0, r[7:0]};
            LH:      data = {{16{r[15]}}, r[15:0]};
            LHU:     data = {16'd0, r[15:0]};
            LW:      data = r;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Splits a byte-addressed load into one or two word reads and returns the aligned, extended result.
module load_align_unit
    import load_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              ld_rsp_valid,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              ld_rsp_err
);

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              split_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;

    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] ext_lo;
    logic [DATA_W-1:0] ext_hi;
    logic [DATA_W-1:0] ext_data;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // Feed the extractor with the word arriving this cycle so the result registers on entry to DONE.
    assign ext_lo = (state == W0) ? mem_rsp_data : lo_q;
    assign ext_hi = (state == W1) ? mem_rsp_data : hi_q;

    load_extract u_extract (
        .lo     (ext_lo),
        .hi     (ext_hi),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            split_q       <= 1'b0;
            lo_q          <= '0;
            hi_q          <= '0;
            ld_req_ready  <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            ld_rsp_valid  <= 1'b0;
            ld_rsp_data   <= '0;
            ld_rsp_err    <= 1'b0;
        end else begin
            ld_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_req_valid) begin
                        addr_q       <= ld_addr;
                        funct3_q     <= ld_funct3;
                        split_q      <= is_split(ld_funct3, ld_addr[1:0]);
                        hi_q         <= '0;
                        ld_req_ready <= 1'b0;
                        if (is_legal_funct3(ld_funct3)) begin
                            state         <= RD0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {ld_addr[ADDR_W-1:2], 2'b00};
                        end else begin
                            // Illegal code: report straight away without touching memory.
                            state        <= DONE;
                            ld_rsp_valid <= 1'b1;
                            ld_rsp_err   <= 1'b1;
                            ld_rsp_data  <= '0;
                        end
                    end
                end
                RD0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= W0;
                    end
                end
                W0: begin
                    if (mem_rsp_valid) begin
                        lo_q <= mem_rsp_data;
                        if (split_q) begin
                            state         <= RD1;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= word_addr + ADDR_W'(WORD_BYTES);
                        end else begin
                            state        <= DONE;
                            ld_rsp_valid <= 1'b1;
                            ld_rsp_err   <= 1'b0;
                            ld_rsp_data  <= ext_data;
                        end
                    end
                end
                RD1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= W1;
                    end
                end
                W1: begin
                    if (mem_rsp_valid) begin
                        hi_q         <= mem_rsp_data;
                        state        <= DONE;
                        ld_rsp_valid <= 1'b1;
                        ld_rsp_err   <= 1'b0;
                        ld_rsp_data  <= ext_data;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    ld_req_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    ld_req_ready  <= 1'b1;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
